// File: rtl/apb_ctrl_pkg.sv
// Shared types and widths for the two-requester APB master.
package apb_ctrl_pkg;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } apb_cmd_t;

endpackage

// File: rtl/apb_rr_arbiter.sv
// Two-way round-robin arbiter: one-hot grant, priority flips to the other
// requester each time a grant is taken.
module apb_rr_arbiter
  import apb_ctrl_pkg::*;
(
  input  logic               pclk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant
);

  logic prio;  // 1: requester 1 is looked at first

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    grant = '0;
    if (prio) begin
      if (req[1])      grant = 2'b10;
      else if (req[0]) grant = 2'b01;
    end else begin
      if (req[0])      grant = 2'b01;
      else if (req[1]) grant = 2'b10;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n)                 prio <= 1'b0;
    else if (advance && |grant) prio <= grant[0];
  end

endmodule

// File: rtl/apb_arb_master.sv
// APB master shared by two requesters: round-robin grant in IDLE, then a
// SETUP/ACCESS transfer with a bounded wait on pready.
module apb_arb_master
  import apb_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic               pclk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_ready,
  input  logic [NUM_REQ-1:0] req_write,
  input  logic [ADDR_W-1:0]  req_addr0,
  input  logic [ADDR_W-1:0]  req_addr1,
  input  logic [DATA_W-1:0]  req_wdata0,
  input  logic [DATA_W-1:0]  req_wdata1,
  output logic [NUM_REQ-1:0] rsp_valid,
  output logic [DATA_W-1:0]  rsp_rdata,
  output logic               rsp_err,
  output logic               psel,
  output logic               penable,
  output logic               pwrite,
  output logic [ADDR_W-1:0]  paddr,
  output logic [DATA_W-1:0]  pwdata,
  input  logic [DATA_W-1:0]  prdata,
  input  logic               pready,
  input  logic               pslaverr
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  apb_state_e         state, state_next;
  apb_cmd_t           cmd;
  logic [NUM_REQ-1:0] grant, win_oh;
  logic [7:0]         to_cnt;
  logic               take, done_ok, done_to;

  apb_rr_arbiter u_arb (
    .pclk    (pclk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .advance (take),
    .grant   (grant)
  );

  assign take    = (state == ST_IDLE) && (|grant);
  assign done_ok = (state == ST_ACCESS) && pready;
  assign done_to = (state == ST_ACCESS) && !pready && (to_cnt == TO_LAST);

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (take) state_next = ST_SETUP;
      ST_SETUP:  state_next = ST_ACCESS;
      ST_ACCESS: if (done_ok || done_to) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // req_ready is gated by rst_n so a held request cannot show a grant during reset.
  always_comb begin
    req_ready = '0;
    psel      = 1'b0;
    penable   = 1'b0;
    case (state)
      ST_IDLE:   if (rst_n) req_ready = grant;
      ST_SETUP:  psel = 1'b1;
      ST_ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      cmd       <= '0;
      win_oh    <= '0;
      to_cnt    <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= '0;
      if (take) begin
        cmd.write <= |(req_write & grant);
        cmd.addr  <= grant[1] ? req_addr1  : req_addr0;
        cmd.wdata <= grant[1] ? req_wdata1 : req_wdata0;
        win_oh    <= grant;
        to_cnt    <= '0;
      end else if ((state == ST_ACCESS) && !pready) begin
        to_cnt <= to_cnt + 8'd1;
      end
      // pready is checked first so it wins a tie with the timeout.
      if (done_ok) begin
        rsp_valid <= win_oh;
        rsp_err   <= pslaverr;
        rsp_rdata <= cmd.write ? '0 : prdata;
      end else if (done_to) begin
        rsp_valid <= win_oh;
        rsp_err   <= 1'b1;
        rsp_rdata <= '0;
      end
    end
  end

  assign pwrite = cmd.write;
  assign paddr  = cmd.addr;
  assign pwdata = cmd.wdata;

endmodule

// File: tb/tb_apb_arb_master.sv
// Directed bench for apb_arb_master (TIMEOUT_CYCLES=4) with hand-computed expectations.
module tb_apb_arb_master;

  logic        pclk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready, req_write, rsp_valid;
  logic [31:0] req_addr0, req_addr1, req_wdata0, req_wdata1;
  logic [31:0] rsp_rdata, paddr, pwdata, prdata;
  logic        rsp_err, psel, penable, pwrite, pready, pslaverr;

  int n_vec = 0;
  int n_err = 0;

  apb_arb_master #(.TIMEOUT_CYCLES(4)) dut (
    .pclk       (pclk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr0  (req_addr0),
    .req_addr1  (req_addr1),
    .req_wdata0 (req_wdata0),
    .req_wdata1 (req_wdata1),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .prdata     (prdata),
    .pready     (pready),
    .pslaverr   (pslaverr)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge pclk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ngrant, nrsp, acc;
    bit got_rsp;

    rst_n = 1'b0; req_valid = '0; req_write = '0;
    req_addr0 = '0; req_addr1 = '0; req_wdata0 = '0; req_wdata1 = '0;
    prdata = '0; pready = 1'b0; pslaverr = 1'b0;

    // Reset values
    #3;
    check("rst_psel", 32'(psel), 0);
    check("rst_penable", 32'(penable), 0);
    check("rst_pwrite", 32'(pwrite), 0);
    check("rst_paddr", paddr, 0);
    check("rst_pwdata", pwdata, 0);
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", 32'(rsp_err), 0);
    @(negedge pclk); rst_n = 1'b1;

    // Single write from requester 0, pready immediately
    cyc();
    req_valid = 2'b01; req_write = 2'b01; req_addr0 = 32'h10; req_wdata0 = 32'hA5A5_0001; pready = 1'b1;
    #1;
    check("wr_grant", 32'(req_ready), 32'h1);
    check("wr_idle_psel", 32'(psel), 0);
    cyc();
    req_valid = '0; req_addr0 = 32'hFFFF_FFFF; req_wdata0 = 32'h0BAD_0BAD;
    #1;
    check("wr_setup_psel", 32'(psel), 1);
    check("wr_setup_penable", 32'(penable), 0);
    check("wr_setup_paddr", paddr, 32'h10);
    check("wr_setup_pwdata", pwdata, 32'hA5A5_0001);
    check("wr_setup_pwrite", 32'(pwrite), 1);
    cyc(); #1;
    check("wr_access_penable", 32'(penable), 1);
    check("wr_access_paddr", paddr, 32'h10);
    check("wr_access_rsp", 32'(rsp_valid), 0);
    cyc(); #1;
    check("wr_rsp_valid", 32'(rsp_valid), 32'h1);
    check("wr_rsp_err", 32'(rsp_err), 0);
    check("wr_rsp_rdata", rsp_rdata, 0);
    check("wr_done_psel", 32'(psel), 0);

    // Read from requester 1 with three wait states (ties with timeout on 4th)
    req_valid = 2'b10; req_write = 2'b00; req_addr1 = 32'h20; pready = 1'b0;
    #1;
    check("rd_grant", 32'(req_ready), 32'h2);
    cyc();
    req_valid = '0;
    #1;
    check("rd_setup_paddr", paddr, 32'h20);
    check("rd_setup_pwrite", 32'(pwrite), 0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      pready = (k == 3);
      prdata = (k == 3) ? 32'hDEAD_BEEF : 32'h0;
      #1;
      check("rd_access_penable", 32'(penable), 1);
      check("rd_access_no_rsp", 32'(rsp_valid), 0);
    end
    cyc(); #1;
    check("rd_rsp_valid", 32'(rsp_valid), 32'h2);
    check("rd_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
    check("rd_rsp_err", 32'(rsp_err), 0);

    // Both requesting for four back-to-back transfers: grants 0,1,0,1
    ngrant = 0; nrsp = 0;
    req_write = 2'b11; req_addr0 = 32'h100; req_addr1 = 32'h104; pready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      cyc();
      req_valid = (ngrant < 4) ? 2'b11 : 2'b00;
      #1;
      if (req_ready != 2'b00) begin
        check("rr_grant", 32'(req_ready), (ngrant % 2 == 0) ? 32'h1 : 32'h2);
        ngrant++;
      end
      if (rsp_valid != 2'b00) begin
        check("rr_rsp", 32'(rsp_valid), (nrsp % 2 == 0) ? 32'h1 : 32'h2);
        nrsp++;
      end
    end
    check("rr_grant_count", ngrant, 4);
    check("rr_rsp_count", nrsp, 4);

    // Timeout: pready never returns, expect exactly 4 ACCESS cycles
    prdata = 32'h1234_5678; pready = 1'b0;
    req_valid = 2'b01; req_write = 2'b00; req_addr0 = 32'h30;
    #1;
    check("to_grant", 32'(req_ready), 32'h1);
    cyc();
    req_valid = '0;
    acc = 0; got_rsp = 1'b0;
    for (int j = 0; j < 20; j++) begin
      cyc(); #1;
      if (rsp_valid != 2'b00) begin
        got_rsp = 1'b1;
        break;
      end
      if (penable) acc++;
    end
    check("to_rsp_seen", 32'(got_rsp), 1);
    check("to_access_cycles", acc, 4);
    check("to_rsp_valid", 32'(rsp_valid), 32'h1);
    check("to_rsp_err", 32'(rsp_err), 1);
    check("to_rsp_rdata", rsp_rdata, 0);

    // Slave error on a write from requester 1; a request withdrawn while busy is dropped
    req_valid = 2'b10; req_write = 2'b10; req_addr1 = 32'h40; req_wdata1 = 32'h55;
    pready = 1'b1; pslaverr = 1'b1;
    #1;
    check("err_grant", 32'(req_ready), 32'h2);
    cyc();
    req_valid = 2'b01;
    #1;
    check("err_busy_no_ready", 32'(req_ready), 0);
    cyc();
    req_valid = '0;
    #1;
    cyc(); #1;
    check("err_rsp_valid", 32'(rsp_valid), 32'h2);
    check("err_rsp_err", 32'(rsp_err), 1);
    check("err_rsp_rdata", rsp_rdata, 0);
    cyc(); #1;
    check("withdrawn_no_psel", 32'(psel), 0);
    check("withdrawn_no_ready", 32'(req_ready), 0);
    pslaverr = 1'b0;

    // Reset during ACCESS: aborts with no response, pointer back to requester 0
    req_valid = 2'b01; req_write = 2'b00; req_addr0 = 32'h50; pready = 1'b0;
    #1;
    check("rst_mid_grant", 32'(req_ready), 32'h1);
    cyc();
    req_valid = '0;
    cyc(); #1;
    check("rst_mid_access", 32'(penable), 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_psel", 32'(psel), 0);
    check("rst_mid_penable", 32'(penable), 0);
    check("rst_mid_paddr", paddr, 0);
    check("rst_mid_rsp", 32'(rsp_valid), 0);
    repeat (2) @(posedge pclk);
    @(negedge pclk); rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc(); #1;
      check("post_rst_no_rsp", 32'(rsp_valid), 0);
      check("post_rst_idle", 32'(psel), 0);
    end
    req_valid = 2'b11;
    #1;
    check("post_rst_rr_ptr", 32'(req_ready), 32'h1);
    cyc();
    req_valid = '0;
    #1;
    check("post_rst_setup_paddr", paddr, 32'h50);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
